// File: rtl/imem_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared definitions for the instruction-memory loader: FSM
//               state encoding, default memory capacity and header length.
//               The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Default instruction memory capacity in 32-bit words
  localparam int C_MAX_WORDS_DEFAULT = 32768;

  // Header carries the 32-bit word count, sent as four bytes
  localparam int C_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK   = 3'd4,
`endif
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_byte_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_byte_packer
// Description : Little-endian byte-to-word assembler. The first accepted byte
//               lands in bits [7:0]. word_valid is raised combinationally in
//               the same cycle as the fourth byte, with that byte driven
//               straight into word[31:24], so the consumer can register the
//               complete word on the accepting edge.
// Revision    : 1.0 - initial release
// Ports       : clock      - rising-edge clock
//               resetn     - asynchronous active-low reset
//               clear      - synchronous restart of the byte count
//               valid      - byte_in is being accepted this cycle
//               byte_in    - incoming byte
//               word       - assembled word (meaningful when word_valid)
//               word_valid - fourth byte of a word is being accepted
// ============================================================================
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_acc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 2'd0;
      r_acc <= 24'd0;
    end else if (clear) begin
      r_cnt <= 2'd0;
      r_acc <= 24'd0;
    end else if (valid) begin
      // Count wraps to 0 after the fourth byte, ready for the next word
      r_cnt <= r_cnt + 2'd1;
      case (r_cnt)
        2'd0:    r_acc[7:0]   <= byte_in;
        2'd1:    r_acc[15:8]  <= byte_in;
        2'd2:    r_acc[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign word       = {byte_in, r_acc};
  assign word_valid = valid && (r_cnt == 2'(C_HDR_BYTES - 1));

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a program image from a byte stream into instruction
//               memory. Stream format: 4-byte little-endian word count N,
//               then N little-endian words. Each completed word is written
//               in the cycle after its last byte is accepted. The processor
//               is held until the load completes.
//               Optional build macro IMEM_LOADER_CHECKSUM_EN: a trailing byte
//               equal to the XOR of all data bytes must follow the data.
// Revision    : 1.0 - initial release
// Parameters  : ADDR_W    - byte-address width of instruction memory
//               MAX_WORDS - memory capacity in 32-bit words
// Ports       : clock, resetn (async active-low)
//               start               - single-cycle load request
//               rx_valid/rx_data    - byte stream in
//               rx_ready            - byte taken when rx_valid && rx_ready
//               mem_we/addr/wdata   - instruction memory write port
//               busy, done, error   - load status
//               cpu_hold            - processor stall until image loaded
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int MAX_WORDS = C_MAX_WORDS_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  // Wide enough to hold N itself (N may equal MAX_WORDS)
  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] r_nwords;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic             w_take;
  logic             w_launch;
  logic [31:0]      w_word;
  logic             w_word_valid;
  logic [IDX_W-1:0] w_idx_next;

  // Only header and data bytes go through the packer; the checksum byte does not
  assign w_take     = rx_valid && rx_ready && ((r_state == HDR) || (r_state == DATA));
  assign w_launch   = start && !busy;
  assign w_idx_next = r_index + IDX_W'(1);

  imem_byte_packer u_packer (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (w_launch),
    .valid      (w_take),
    .byte_in    (rx_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b1;
      r_index   <= '0;
      r_nwords  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum    <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state  <= HDR;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            r_index  <= '0;
            r_nwords <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum   <= 8'd0;
`endif
          end
        end

        HDR: begin
          if (w_word_valid) begin
            r_nwords <= w_word[IDX_W-1:0];
            if (w_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              // Empty image still carries a checksum byte (expected 0x00)
              r_state  <= CHK;
`else
              r_state  <= DONE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else if (w_word > 32'(MAX_WORDS)) begin
              r_state  <= ERR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              r_state  <= DATA;
            end
          end
        end

        DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_take) begin
            r_csum <= r_csum ^ rx_data;
          end
`endif
          if (w_word_valid) begin
            r_state   <= WRITE;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'({r_index, 2'b00});
            mem_wdata <= w_word;
          end
        end

        WRITE: begin
          r_index <= w_idx_next;
          if (w_idx_next < r_nwords) begin
            r_state  <= DATA;
            rx_ready <= 1'b1;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state  <= CHK;
            rx_ready <= 1'b1;
`else
            r_state  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (rx_valid && rx_ready) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (rx_data == r_csum) begin
              r_state  <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state  <= ERR;
              error    <= 1'b1;
            end
          end
        end
`endif

        default: begin
          r_state  <= IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The parameters SHALL be:
- ADDR_W, default 17, byte-address width of instruction memory.
- MAX_WORDS, default 32768, instruction memory capacity in 32-bit words.

REQ-002 The ports SHALL be:
- clock, input, 1, sole clock; all state updates on rising edge.
- resetn, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle load request.
- rx_valid, input, 1, byte-stream valid.
- rx_data, input, 8, byte-stream data.
- rx_ready, output, 1, byte accepted when rx_valid && rx_ready on a rising edge.
- mem_we, output, 1, instruction-memory write strobe.
- mem_addr, output, ADDR_W, word-aligned byte address, [1:0] always 0.
- mem_wdata, output, 32, instruction word.
- busy, output, 1, load in progress.
- done, output, 1, load completed successfully.
- error, output, 1, load aborted.
- cpu_hold, output, 1, keeps the processor stalled until the image is loaded.

Function
REQ-003 The FSM SHALL have states IDLE, HDR, DATA, WRITE, CHK, DONE, ERR.
REQ-004 IDLE: rx_ready=0; start=1 SHALL enter HDR with the byte counter, word index and checksum cleared.
REQ-005 HDR: rx_ready=1; four accepted bytes SHALL form the 32-bit word count N, little-endian (first byte = bits [7:0]).
REQ-006 After the 4th header byte, the next state SHALL be:
- N==0: DONE.
- N>MAX_WORDS: ERR.
- otherwise: DATA.
REQ-007 DATA: rx_ready=1; four accepted bytes SHALL assemble one word little-endian; the 4th byte SHALL move to WRITE on the next edge.
REQ-008 WRITE: SHALL last exactly one cycle with:
- mem_we=1, mem_addr=index<<2, mem_wdata=assembled word, rx_ready=0.
- index incremented.
- next state: DATA if index+1<N, else CHK (macro defined) or DONE.
REQ-009 Latency: mem_we SHALL assert in the cycle immediately after the 4th data byte is accepted.
REQ-010 rx_valid=0 in HDR/DATA SHALL stall without losing partial bytes; gaps between bytes are unbounded.
REQ-011 Word index SHALL not wrap: N is bounded by REQ-006, and the last write goes to address (N-1)*4.
REQ-012 DONE: done=1, cpu_hold=0, busy=0; SHALL hold until start=1, which SHALL re-enter HDR and clear done.
REQ-013 ERR: error=1 (sticky), cpu_hold=1, busy=0; start=1 SHALL re-enter HDR and clear error.
REQ-014 busy SHALL be 1 exactly in HDR, DATA, WRITE, CHK; start while busy SHALL be ignored.
REQ-015 mem_we SHALL be 1 only in WRITE; mem_addr/mem_wdata SHALL hold their last values otherwise.

Reset
REQ-016 resetn=0 SHALL immediately force:
- state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- busy=0, done=0, error=0, cpu_hold=1.
- all counters and the checksum to 0.
REQ-017 Reset mid-load SHALL abandon the partial load; words already written SHALL not be retracted.

Configuration
REQ-018 With IMEM_LOADER_CHECKSUM_EN defined:
- the SHALL maintain a running XOR of all data bytes (header excluded).
- CHK SHALL accept one trailing byte (rx_ready=1): match goes to DONE, mismatch to ERR.
- N==0 SHALL still pass through CHK with expected value 0x00.
REQ-019 Without IMEM_LOADER_CHECKSUM_EN: CHK SHALL not exist, no trailing byte is consumed, and ERR SHALL be reachable only via REQ-006.

Structure
REQ-020 Shared package imem_loader_pkg SHALL hold the state enum, the default MAX_WORDS, and the header length constant (4).
REQ-021 Byte-to-word little-endian assembly SHALL be a sub-module imem_byte_packer (byte in, valid, clear; word out, word_valid).

Verification
REQ-022 The bench SHALL cover:
- start; bytes 02 00 00 00, 13 07 00 58, 37 27 00 00 -> writes addr 0x0 = 0x58000713, addr 0x4 = 0x00002737; done=1, cpu_hold=0.
- header 00 00 00 00 -> done=1 with no mem_we; plus a checksum byte 00 when the macro is defined.
- header 01 80 00 00 (N=32769) -> error=1, cpu_hold=1, no mem_we.
- rx_valid toggling every other cycle during a 3-word load -> identical writes, no lost bytes.
- resetn pulsed low after 6 data bytes -> all outputs at reset values; a new start completes a clean load.
- Macro defined: load 1 word 01 02 03 04 with trailing 04 -> done; with trailing 05 -> error.
